// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state codes, opcodes, control encodings and next-state helper for multicycle_controller
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_IEXEC   = 4'd11,
    S_IWB     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_OR    = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // Zero-wait successor; op_in is only looked at in DECODE, later states use the held copy.
  function automatic state_t next_state(state_t s, logic [5:0] op_held, logic [5:0] op_in);
    state_t n;
    n = S_INIT;
    case (s)
      S_INIT:    n = S_FETCH;
      S_FETCH:   n = S_DECODE;
      S_DECODE: begin
        case (op_in)
          OP_LW, OP_SW:    n = S_MEMADDR;
          OP_RTYPE:        n = S_EXEC;
          OP_BEQ, OP_BNE:  n = S_BRANCH;
          OP_J, OP_JAL:    n = S_JUMP;
          OP_ADDI, OP_ORI: n = S_IEXEC;
          default:         n = S_FETCH;
        endcase
      end
      S_MEMADDR: n = (op_held == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   n = S_MEMWB;
      S_EXEC:    n = S_ALUWB;
      S_IEXEC:   n = S_IWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_IWB: n = S_FETCH;
      default:   n = S_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - Moore output decode from registered state and held opcode
module mc_output_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       se_control,
  output logic       comp_control,
  output logic       jal_control,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    se_control    = 1'b0;
    comp_control  = 1'b0;
    jal_control   = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_FUNCT;
    pc_source     = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_BRANCH;
        alu_op     = ALUOP_ADD;
        se_control = 1'b1;
      end
      S_MEMADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        se_control = 1'b1;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: reg_write = 1'b1;
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: alu_src_a = 1'b1;
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_TARGET;
        comp_control  = (op == OP_BNE);
      end
      S_JUMP: begin
        pc_write    = 1'b1;
        pc_source   = PCSRC_JUMP;
        reg_write   = (op == OP_JAL);
        jal_control = (op == OP_JAL);
        mem_to_reg  = (op == OP_JAL);
      end
      S_IEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = (op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
        se_control = (op != OP_ORI);
      end
      S_IWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM; define MC_WAIT_EN for memory wait states and timeout
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       SEControl,
  output logic       Comp_Control,
  output logic       jal_Control,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       MemErr,
  output logic [3:0] State
);

  state_t     state;
  logic [5:0] op_q;
  logic       dec_pc_write;

  assign State = state;

  mc_output_decode u_decode (
    .state         (state),
    .op            (op_q),
    .pc_write      (dec_pc_write),
    .pc_write_cond (PCWriteCond),
    .i_or_d        (IorD),
    .mem_read      (MemRead),
    .mem_write     (MemWrite),
    .ir_write      (IRWrite),
    .mem_to_reg    (MemtoReg),
    .reg_dst       (RegDst),
    .reg_write     (RegWrite),
    .alu_src_a     (ALUSrcA),
    .se_control    (SEControl),
    .comp_control  (Comp_Control),
    .jal_control   (jal_Control),
    .alu_src_b     (ALUSrcB),
    .alu_op        (ALUOp),
    .pc_source     (PCSource)
  );

`ifdef MC_WAIT_EN
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  logic [CW-1:0] wait_cnt;
  logic          mem_err_q;
  logic          mem_state;
  logic          hold;
  logic          timeout;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign hold      = mem_state && !MemReady;
  // The held cycle that would bring the count to WAIT_MAX is the timeout cycle itself.
  assign timeout   = hold && (wait_cnt == CW'(WAIT_MAX - 1));
  assign MemErr    = mem_err_q;
  // The FETCH re-entered after a timeout must not advance the PC a second time.
  assign PCWrite   = dec_pc_write && !mem_err_q;
`else
  logic unused_inputs;
  assign unused_inputs = MemReady | (WAIT_MAX < 1);
  assign MemErr        = 1'b0;
  assign PCWrite       = dec_pc_write;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_INIT;
      op_q  <= '0;
`ifdef MC_WAIT_EN
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
`endif
    end else begin
`ifdef MC_WAIT_EN
      mem_err_q <= 1'b0;
      if (timeout) begin
        state     <= S_FETCH;
        wait_cnt  <= '0;
        mem_err_q <= 1'b1;
      end else if (hold) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
        state    <= next_state(state, op_q, Opcode);
      end
`else
      state <= next_state(state, op_q, Opcode);
`endif
      if (state == S_DECODE) op_q <= Opcode;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed and randomized checks of multicycle_controller against an instruction-level model
module tb_multicycle_controller;

  localparam int WAIT_MAX = 3;
`ifdef MC_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       Clk, Rst, MemReady;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, SEControl, Comp_Control, jal_Control;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       MemErr;
  logic [3:0] State;

  multicycle_controller #(.WAIT_MAX(WAIT_MAX)) dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .SEControl(SEControl),
    .Comp_Control(Comp_Control), .jal_Control(jal_Control), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .MemErr(MemErr), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, se, comp, jal;
    logic [1:0] srcb, aluop, pcsrc;
  } ctl_t;

  ctl_t dut_ctl;
  assign dut_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                    RegWrite, ALUSrcA, SEControl, Comp_Control, jal_Control, ALUSrcB, ALUOp, PCSource};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t expect_ctl(int s, logic [5:0] op, bit err);
    ctl_t c;
    c = '0;
    case (s)
      1:  begin c.mrd = 1; c.irw = 1; c.srcb = 2'b01; c.aluop = 2'b10; c.pcw = !err; end
      2:  begin c.srcb = 2'b11; c.aluop = 2'b10; c.se = 1; end
      3:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b10; c.se = 1; end
      4:  begin c.iord = 1; c.mrd = 1; end
      5:  c.rw = 1;
      6:  begin c.iord = 1; c.mwr = 1; end
      7:  c.srca = 1;
      8:  begin c.rw = 1; c.rdst = 1; c.m2r = 1; end
      9:  begin c.srca = 1; c.aluop = 2'b11; c.pcwc = 1; c.pcsrc = 2'b01; c.comp = (op == 6'b000101); end
      10: begin
        c.pcw = 1; c.pcsrc = 2'b10;
        if (op == 6'b000011) begin c.rw = 1; c.jal = 1; c.m2r = 1; end
      end
      11: begin
        c.srca = 1; c.srcb = 2'b10;
        if (op == 6'b001101) c.aluop = 2'b01;
        else begin c.aluop = 2'b10; c.se = 1; end
      end
      12: begin c.rw = 1; c.m2r = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Instruction-level model: DECODE queues the rest of the instruction's state walk.
  int         m_state;
  logic [5:0] m_op;
  int         m_cnt;
  bit         m_err;
  bit         m_valid = 1'b0;
  int         path[$];

  always @(posedge Clk) begin
    if (Rst) begin
      m_state = 0; m_op = '0; m_cnt = 0; m_err = 0; path.delete(); m_valid = 1'b1;
    end else if (m_valid) begin
      m_err = 0;
      if (WAIT_EN && (m_state == 1 || m_state == 4 || m_state == 6) && !MemReady) begin
        m_cnt++;
        if (m_cnt == WAIT_MAX) begin
          m_cnt = 0; m_err = 1; m_state = 1; path.delete();
        end
      end else begin
        m_cnt = 0;
        if (m_state == 0) m_state = 1;
        else if (m_state == 1) m_state = 2;
        else begin
          if (m_state == 2) begin
            m_op = Opcode;
            case (Opcode)
              6'b100011: path = '{3, 4, 5};
              6'b101011: path = '{3, 6};
              6'b000000: path = '{7, 8};
              6'b000100, 6'b000101: path = '{9};
              6'b000010, 6'b000011: path = '{10};
              6'b001000, 6'b001101: path = '{11, 12};
              default: path.delete();
            endcase
          end
          m_state = (path.size() > 0) ? path.pop_front() : 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("state", 32'(State), 32'(m_state));
      chk("memerr", 32'(MemErr), 32'(m_err));
      chk("ctl", 32'(dut_ctl), 32'(expect_ctl(m_state, m_op, m_err)));
    end
  end

  int         lw_seq[6] = '{1, 2, 3, 4, 5, 1};
  logic [5:0] ops[10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                          6'b000010, 6'b000011, 6'b001000, 6'b001101, 6'b111111};

  task automatic run_branch(input logic [5:0] op, input bit is_bne);
    Opcode = op;
    @(negedge Clk);
    @(negedge Clk);
    chk("br_state", 32'(State), 32'd9);
    chk("br_pcwritecond", 32'(PCWriteCond), 32'd1);
    chk("br_comp", 32'(Comp_Control), 32'(is_bne));
    chk("br_pcsource", 32'(PCSource), 32'd1);
    @(negedge Clk);
    chk("br_back_fetch", 32'(State), 32'd1);
  endtask

  initial begin
    int k;
    int burst;
    Rst = 1'b1; Opcode = '0; MemReady = 1'b1;
    repeat (2) @(negedge Clk);
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_ctl", 32'(dut_ctl), 32'd0);
    chk("reset_memerr", 32'(MemErr), 32'd0);

    Rst = 1'b0; Opcode = 6'b100011;
    foreach (lw_seq[i]) begin
      @(negedge Clk);
      chk("lw_state", 32'(State), 32'(lw_seq[i]));
      chk("lw_regwrite", 32'(RegWrite), 32'(lw_seq[i] == 5));
    end

    run_branch(6'b000101, 1'b1);
    run_branch(6'b000100, 1'b0);

    Opcode = 6'b000011;
    @(negedge Clk);
    @(negedge Clk);
    chk("jal_state", 32'(State), 32'd10);
    chk("jal_pcwrite", 32'(PCWrite), 32'd1);
    chk("jal_pcsource", 32'(PCSource), 32'd2);
    chk("jal_regwrite", 32'(RegWrite), 32'd1);
    chk("jal_control", 32'(jal_Control), 32'd1);
    @(negedge Clk);
    chk("jal_back_fetch", 32'(State), 32'd1);

    Opcode = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("nop_state", 32'(State), 32'(i == 0 ? 2 : 1));
      chk("nop_writes", 32'({RegWrite, MemWrite, PCWriteCond}), 32'd0);
    end

    Opcode = 6'b100011;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_mid_memrd", 32'(State), 32'd4);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_init_state", 32'(State), 32'd0);
    chk("rst_init_ctl", 32'(dut_ctl), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_then_fetch", 32'(State), 32'd1);

`ifdef MC_WAIT_EN
    MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("wait_hold_state", 32'(State), 32'd1);
      chk("wait_hold_err", 32'(MemErr), 32'd0);
    end
    @(negedge Clk);
    chk("timeout_err", 32'(MemErr), 32'd1);
    chk("timeout_state", 32'(State), 32'd1);
    chk("timeout_pcwrite", 32'(PCWrite), 32'd0);
    MemReady = 1'b1; Opcode = 6'b111111;
    @(negedge Clk);
    chk("after_timeout_decode", 32'(State), 32'd2);
    chk("after_timeout_err", 32'(MemErr), 32'd0);
    @(negedge Clk);
    MemReady = 1'b0;
    @(negedge Clk);
    chk("ready2_hold", 32'(State), 32'd1);
    MemReady = 1'b1;
    @(negedge Clk);
    chk("ready2_decode", 32'(State), 32'd2);
    chk("ready2_err", 32'(MemErr), 32'd0);
`endif

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      Rst = ($urandom_range(0, 79) == 0);
      k = $urandom_range(0, 11);
      Opcode = (k < 10) ? ops[k] : 6'($urandom);
      if (burst > 0) begin
        MemReady = 1'b0;
        burst--;
      end else if ($urandom_range(0, 19) == 0) begin
        MemReady = 1'b0;
        burst = $urandom_range(0, 5);
      end else begin
        MemReady = ($urandom_range(0, 3) != 0);
      end
      @(negedge Clk);
    end
    Rst = 1'b0; MemReady = 1'b1;
    @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: Clk and Rst are sampled on the rising edge of Clk only.
REQ-002 The block SHALL have one parameter: WAIT_MAX, default 15, the maximum number of memory wait cycles before a timeout (used only when MC_WAIT_EN is defined).
REQ-003 Clk  in  1  system clock.
REQ-004 Rst  in  1  synchronous active-high reset.
REQ-005 Opcode  in  6  instruction bits 31:26, taken from the instruction register.
REQ-006 MemReady  in  1  memory access complete; the port exists in all builds.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  PC and memory control.
REQ-008 MemtoReg, RegDst, RegWrite, ALUSrcA, SEControl, Comp_Control, jal_Control  out  1 each  register-file and ALU-source control.
REQ-009 ALUSrcB, ALUOp, PCSource  out  2 each  ALU operand select, ALU operation class, next-PC select.
REQ-010 MemErr  out  1  one-cycle pulse on memory timeout.
REQ-011 State  out  4  current state code, for debug.

Function
REQ-012 The block SHALL be a Moore FSM: every output is decoded from the registered state only; any output not listed for a state SHALL be 0.
REQ-013 State codes SHALL be: INIT=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12; codes 13-15 SHALL go to INIT on the next cycle.
REQ-014 ALUOp encoding SHALL be: 00 R-type (funct decode), 01 OR, 10 add, 11 subtract/compare.
REQ-015 INIT: all outputs 0; next state FETCH.
REQ-016 FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=10, PCWrite=1; next state DECODE.
REQ-017 DECODE: ALUSrcB=11, ALUOp=10, SEControl=1 (precomputes the branch target); next state by Opcode:
- 100011 (lw) or 101011 (sw) -> MEMADDR
- 000000 (R-type) -> EXEC
- 000100 (beq) or 000101 (bne) -> BRANCH
- 000010 (j) or 000011 (jal) -> JUMP
- 001000 (addi) or 001101 (ori) -> IEXEC
- any other opcode -> FETCH (treated as a no-op)
REQ-018 Opcode SHALL be sampled only in DECODE; changes to Opcode in other states SHALL have no effect.
REQ-019 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=10, SEControl=1; next state MEMRD for lw, MEMWR for sw.
REQ-020 MEMRD: IorD=1, MemRead=1; next state MEMWB.
REQ-021 MEMWB: RegWrite=1, MemtoReg=0, RegDst=0; next state FETCH.
REQ-022 MEMWR: IorD=1, MemWrite=1; next state FETCH.
REQ-023 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=00; next state ALUWB.
REQ-024 ALUWB: RegWrite=1, RegDst=1, MemtoReg=1; next state FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUOp=11, PCWriteCond=1, PCSource=01, Comp_Control=1 for bne only; next state FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10; for jal also RegWrite=1, jal_Control=1, MemtoReg=1; next state FETCH.
REQ-027 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=10 with SEControl=1 for addi, ALUOp=01 with SEControl=0 for ori; next state IWB.
REQ-028 IWB: RegWrite=1, RegDst=0, MemtoReg=1; next state FETCH.
REQ-029 The opcode captured in DECODE SHALL be held in an internal register until the next DECODE, so that later states can select between lw/sw, beq/bne, j/jal and addi/ori.
REQ-030 Instruction latency with zero-wait memory SHALL be: lw 5 cycles; sw, R-type, addi and ori 4 cycles; beq, bne, j and jal 3 cycles.

Reset
REQ-031 Rst=1 at a rising clock edge SHALL force state INIT, clear the opcode register, the wait counter and MemErr, and take priority over every transition, including mid-instruction and mid-wait.
REQ-032 While Rst=1 all outputs SHALL be 0; the first FETCH SHALL occur one cycle after the first edge with Rst=0.

Configuration
REQ-033 When the macro MC_WAIT_EN is defined, FETCH, MEMRD and MEMWR SHALL hold their state and outputs while MemReady=0, and advance on the first cycle with MemReady=1.
REQ-034 With MC_WAIT_EN defined, a wait counter SHALL count held cycles; if it reaches WAIT_MAX with MemReady still 0, the FSM SHALL pulse MemErr for one cycle, go to FETCH, and clear the counter; PCWrite SHALL NOT assert on the timeout cycle.
REQ-035 Without MC_WAIT_EN, MemReady SHALL be ignored, the counter SHALL be absent, MemErr SHALL be tied to 0, and each memory state SHALL last exactly one cycle.

Structure
REQ-036 The state codes, the opcode constants and the ALUOp/PCSource/ALUSrcB encodings SHALL live in a shared package, mc_ctrl_pkg.
REQ-037 The output decode SHALL be a sub-module, mc_output_decode (state and held opcode in, control signals out); the state register, next-state logic and wait counter SHALL remain in the top module.

Verification
REQ-038 Reset then lw (Opcode=100011) -> State sequence 0,1,2,3,4,5,1; RegWrite=1 only in state 5.
REQ-039 bne (000101) -> in BRANCH: PCWriteCond=1, Comp_Control=1, PCSource=01; beq gives the same with Comp_Control=0.
REQ-040 jal (000011) -> in JUMP: PCWrite=1, PCSource=10, RegWrite=1, jal_Control=1; back in FETCH on the next cycle.
REQ-041 Opcode=111111 in DECODE -> next state FETCH, and no RegWrite, MemWrite or PCWriteCond is asserted.
REQ-042 Rst asserted during MEMRD -> next state INIT with all outputs 0, then FETCH one cycle after Rst falls.
REQ-043 With MC_WAIT_EN and WAIT_MAX=3, MemReady held at 0 in FETCH -> MemErr pulses after 3 wait cycles and the FSM returns to FETCH; MemReady=1 on the 2nd wait cycle instead -> advances to DECODE with MemErr=0.
